// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the SM83 control unit: datapath strobe
//               encodings, sequencing step and the decoded control word,
//               plus opcode-class helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic {
        PcNextSame = 1'b0,
        PcNextInc  = 1'b1
    } pc_next_e;

    typedef enum logic [1:0] {
        RegSelA        = 2'd0,
        RegSelReg8Src  = 2'd1,   // opcode[2:0]
        RegSelReg8Dest = 2'd2    // opcode[5:3]
    } reg_sel_e;

    typedef enum logic {
        RegInputAlu = 1'b0,
        RegInputMem = 1'b1
    } reg_input_e;

    typedef enum logic [1:0] {
        StepExec0  = 2'd0,
        StepExec1  = 2'd1,
        StepHalted = 2'd2
    } step_e;

    typedef struct packed {
        pc_next_e   pc_next;
        logic       inst_load;
        reg_sel_e   reg_read1_sel;
        reg_sel_e   reg_read2_sel;
        reg_sel_e   reg_write_sel;
        logic       reg_write_enable;
        reg_input_e reg_write_input;
        logic       mem_enable;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t C_CTRL_IDLE = '{
        pc_next:          PcNextSame,
        inst_load:        1'b0,
        reg_read1_sel:    RegSelA,
        reg_read2_sel:    RegSelA,
        reg_write_sel:    RegSelA,
        reg_write_enable: 1'b0,
        reg_write_input:  RegInputAlu,
        mem_enable:       1'b0,
        mem_write:        1'b0
    };

    localparam logic [7:0] C_OP_HALT = 8'h76;
    localparam logic [2:0] C_REG_HL  = 3'd6;   // (HL) memory operand slot

    // LD r,n : 00 rrr 110 with rrr != (HL)
    function automatic logic is_ld_imm(input logic [7:0] op);
        return (op[7:6] == 2'b00) && (op[2:0] == C_REG_HL) && (op[5:3] != C_REG_HL);
    endfunction

    // LD r,r' : 01 ddd sss, neither operand (HL); this also excludes HALT
    function automatic logic is_ld_rr(input logic [7:0] op);
        return (op[7:6] == 2'b01) && (op[2:0] != C_REG_HL) && (op[5:3] != C_REG_HL);
    endfunction

    // ALU A,r : 10 ooo sss with sss != (HL)
    function automatic logic is_alu_r(input logic [7:0] op);
        return (op[7:6] == 2'b10) && (op[2:0] != C_REG_HL);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_decode
// Description : Combinational (opcode, step) -> control word decoder. Also
//               reports whether this M-cycle fetches the next opcode and
//               which step follows when it does not.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] i_opcode,
    input  step_e      i_step,
    output ctrl_t      o_ctrl,
    output logic       o_fetch,
    output step_e      o_step_next
);

    // Decode the control word; the fetch M-cycle also carries write-back
    // of the instruction it retires.
    always_comb begin
        o_ctrl      = C_CTRL_IDLE;
        o_fetch     = 1'b0;
        o_step_next = i_step;
        case (i_step)
            StepExec0: begin
                if (i_opcode == C_OP_HALT) begin
                    o_step_next = StepHalted;
                end else if (is_ld_imm(i_opcode)) begin
                    // Read the immediate byte straight into the destination.
                    o_ctrl.pc_next          = PcNextInc;
                    o_ctrl.mem_enable       = 1'b1;
                    o_ctrl.reg_write_sel    = RegSelReg8Dest;
                    o_ctrl.reg_write_input  = RegInputMem;
                    o_ctrl.reg_write_enable = 1'b1;
                    o_step_next             = StepExec1;
                end else begin
                    o_ctrl.pc_next    = PcNextInc;
                    o_ctrl.inst_load  = 1'b1;
                    o_ctrl.mem_enable = 1'b1;
                    o_fetch           = 1'b1;
                    o_step_next       = StepExec0;
                    if (is_ld_rr(i_opcode)) begin
                        o_ctrl.reg_read2_sel    = RegSelReg8Src;
                        o_ctrl.reg_write_sel    = RegSelReg8Dest;
                        o_ctrl.reg_write_enable = 1'b1;
                    end else if (is_alu_r(i_opcode)) begin
                        o_ctrl.reg_read1_sel    = RegSelA;
                        o_ctrl.reg_read2_sel    = RegSelReg8Src;
                        o_ctrl.reg_write_sel    = RegSelA;
                        o_ctrl.reg_write_enable = 1'b1;
                    end
                end
            end
            StepHalted: begin
                o_step_next = StepHalted;
            end
            default: begin
                // Exec1 (and any illegal encoding) is a plain fetch.
                o_ctrl.pc_next    = PcNextInc;
                o_ctrl.inst_load  = 1'b1;
                o_ctrl.mem_enable = 1'b1;
                o_fetch           = 1'b1;
                o_step_next       = StepExec0;
            end
        endcase
    end

endmodule : cpu_decode
`default_nettype wire

// File: rtl/cpu_control.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control
// Description : SM83 control unit. Holds the opcode and step registers,
//               advances them at the end of each M-cycle (t_cycle == 3) and
//               presents the decoded datapath strobes for the whole M-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] t_cycle,
    input  logic [7:0] mem_data_in,
    output pc_next_e   pc_next,
    output logic       inst_load,
    output reg_sel_e   reg_read1_sel,
    output reg_sel_e   reg_read2_sel,
    output reg_sel_e   reg_write_sel,
    output logic       reg_write_enable,
    output reg_input_e reg_write_input,
    output logic       mem_enable,
    output logic       mem_write
);

    logic [7:0] r_opcode;
    step_e      r_step;
    ctrl_t      w_ctrl;
    logic       w_fetch;
    step_e      w_step_next;

    cpu_decode u_decode (
        .i_opcode    (r_opcode),
        .i_step      (r_step),
        .o_ctrl      (w_ctrl),
        .o_fetch     (w_fetch),
        .o_step_next (w_step_next)
    );

    // State advances only on the final T-cycle; a fetch latches the new opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode <= 8'h00;
            r_step   <= StepExec0;
        end else if (t_cycle == 2'd3) begin
            if (w_fetch) begin
                r_opcode <= mem_data_in;
                r_step   <= StepExec0;
            end else begin
                r_step   <= w_step_next;
            end
        end
    end

    assign pc_next          = w_ctrl.pc_next;
    assign inst_load        = w_ctrl.inst_load;
    assign reg_read1_sel    = w_ctrl.reg_read1_sel;
    assign reg_read2_sel    = w_ctrl.reg_read2_sel;
    assign reg_write_sel    = w_ctrl.reg_write_sel;
    assign reg_write_enable = w_ctrl.reg_write_enable;
    assign reg_write_input  = w_ctrl.reg_write_input;
    assign mem_enable       = w_ctrl.mem_enable;
    assign mem_write        = w_ctrl.mem_write;

endmodule : cpu_control
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control
// Description : Directed self-checking bench for cpu_control. Each M-cycle's
//               outputs are packed into one word
//               {pc_next, inst_load, rd1, rd2, wsel, we, win, mem_en, mem_wr}
//               and compared with hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control;
    import cpu_pkg::*;

    // Expected packed control words
    localparam logic [11:0] C_FETCH = 12'b1_1_00_00_00_0_0_1_0;
    localparam logic [11:0] C_IDLE  = 12'b0_0_00_00_00_0_0_0_0;
    localparam logic [11:0] C_LDN0  = 12'b1_0_00_00_10_1_1_1_0;
    localparam logic [11:0] C_LDRR  = 12'b1_1_00_01_10_1_0_1_0;
    localparam logic [11:0] C_ALU   = 12'b1_1_00_01_00_1_0_1_0;

    logic       clk;
    logic       reset;
    logic [1:0] t_cycle;
    logic [7:0] mem_data_in;
    pc_next_e   pc_next;
    logic       inst_load;
    reg_sel_e   reg_read1_sel;
    reg_sel_e   reg_read2_sel;
    reg_sel_e   reg_write_sel;
    logic       reg_write_enable;
    reg_input_e reg_write_input;
    logic       mem_enable;
    logic       mem_write;
    logic [11:0] w_obs;

    int errors = 0;
    int checks = 0;

    cpu_control dut (
        .clk              (clk),
        .reset            (reset),
        .t_cycle          (t_cycle),
        .mem_data_in      (mem_data_in),
        .pc_next          (pc_next),
        .inst_load        (inst_load),
        .reg_read1_sel    (reg_read1_sel),
        .reg_read2_sel    (reg_read2_sel),
        .reg_write_sel    (reg_write_sel),
        .reg_write_enable (reg_write_enable),
        .reg_write_input  (reg_write_input),
        .mem_enable       (mem_enable),
        .mem_write        (mem_write)
    );

    assign w_obs = {pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel,
                    reg_write_enable, reg_write_input, mem_enable, mem_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full M-cycle with the bus showing `data`; returns 1 ns after the
    // t_cycle==3 edge so outputs reflect the following M-cycle.
    task automatic mcycle(input logic [7:0] data);
        for (int t = 0; t < 4; t++) begin
            t_cycle     = t[1:0];
            mem_data_in = data;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        t_cycle = 2'd0;
        mem_data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", w_obs, C_FETCH);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", w_obs, C_FETCH);
        end
        for (int i = 0; i < 3; i++) begin
            mcycle(8'h00);
            checks++;
            if (w_obs !== C_FETCH) begin
                errors++;
                $display("FAIL nop_stream[%0d]: got %b expected %b", i, w_obs, C_FETCH);
            end
        end
    endtask

    task automatic test_ld_imm;
        mcycle(8'h3E);
        checks++;
        if (w_obs !== C_LDN0) begin
            errors++;
            $display("FAIL ld_imm_exec0: got %b expected %b", w_obs, C_LDN0);
        end
        // 0x5A is the immediate operand, not an opcode
        mcycle(8'h5A);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL ld_imm_exec1: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'h00);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL ld_imm_after: got %b expected %b", w_obs, C_FETCH);
        end
    endtask

    task automatic test_ld_rr;
        mcycle(8'h78);
        checks++;
        if (w_obs !== C_LDRR) begin
            errors++;
            $display("FAIL ld_rr_78: got %b expected %b", w_obs, C_LDRR);
        end
        mcycle(8'h7E);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL ld_rr_hl_7E: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'h00);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL ld_rr_after: got %b expected %b", w_obs, C_FETCH);
        end
    endtask

    task automatic test_alu;
        mcycle(8'h80);
        checks++;
        if (w_obs !== C_ALU) begin
            errors++;
            $display("FAIL alu_80: got %b expected %b", w_obs, C_ALU);
        end
        mcycle(8'hBF);
        checks++;
        if (w_obs !== C_ALU) begin
            errors++;
            $display("FAIL alu_BF: got %b expected %b", w_obs, C_ALU);
        end
        mcycle(8'h86);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL alu_hl_86: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'hC6);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL imm_C6: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'h00);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL alu_after: got %b expected %b", w_obs, C_FETCH);
        end
    endtask

    task automatic test_halt;
        mcycle(8'h76);
        checks++;
        if (w_obs !== C_IDLE) begin
            errors++;
            $display("FAIL halt_exec0: got %b expected %b", w_obs, C_IDLE);
        end
        for (int i = 0; i < 12; i++) begin
            mcycle(8'h00);
            checks++;
            if (w_obs !== C_IDLE) begin
                errors++;
                $display("FAIL halted[%0d]: got %b expected %b", i, w_obs, C_IDLE);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL halt_async_reset: got %b expected %b", w_obs, C_FETCH);
        end
        #1 reset = 1'b1;
        mcycle(8'h00);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL halt_after_reset: got %b expected %b", w_obs, C_FETCH);
        end
    endtask

    task automatic test_reset_mid;
        mcycle(8'h06);
        checks++;
        if (w_obs !== C_LDN0) begin
            errors++;
            $display("FAIL ld_b_exec0: got %b expected %b", w_obs, C_LDN0);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b", w_obs, C_FETCH);
        end
        #1 reset = 1'b1;
        mcycle(8'h36);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL op_36: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'h00);
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL op_36_after: got %b expected %b", w_obs, C_FETCH);
        end
    endtask

    // Edges with t_cycle != 3 must not latch the bus value.
    task automatic test_tcycle_gate;
        mem_data_in = 8'h76;
        for (int t = 0; t < 3; t++) begin
            t_cycle = t[1:0];
            repeat (2) @(posedge clk);
            #1;
        end
        checks++;
        if (w_obs !== C_FETCH) begin
            errors++;
            $display("FAIL tcycle_gate: got %b expected %b", w_obs, C_FETCH);
        end
        mcycle(8'h80);
        checks++;
        if (w_obs !== C_ALU) begin
            errors++;
            $display("FAIL tcycle_gate_resume: got %b expected %b", w_obs, C_ALU);
        end
    endtask

    initial begin
        reset       = 1'b0;
        t_cycle     = 2'd0;
        mem_data_in = 8'h00;
        test_reset();
        test_ld_imm();
        test_ld_rr();
        test_alu();
        test_halt();
        test_reset_mid();
        test_tcycle_gate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cpu_control
`default_nettype wire
